// File: rtl/branch_fetch_ctrl.sv
// Instruction-stream front end: forwards ordinary opcodes and drives the
// program counter's load/offset controls for two-byte branches and HALT.
module branch_fetch_ctrl #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                res,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          instr,
  input  logic                zero,
  input  logic                carry,
  output logic                wr_en,
  output logic                add_offset,
  output logic [PC_WIDTH-1:0] counteradress,
  output logic                op_valid,
  output logic [7:0]          op_code,
  output logic                halted,
  output logic [7:0]          branch_count
);

  localparam logic [7:0] OP_JMP  = 8'hF0;
  localparam logic [7:0] OP_JR   = 8'hF4;
  localparam logic [7:0] OP_JZ   = 8'hF8;
  localparam logic [7:0] OP_JC   = 8'hFC;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, HALT} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_JMP, BR_JR, BR_JZ, BR_JC} br_kind_t;

  state_t     state_q, state_d;
  br_kind_t   kind_q, kind_d;
  logic [7:0] count_q, count_d;
  logic       taken, relative;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= FETCH_OP;
      kind_q  <= BR_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    count_d       = count_q;
    taken         = 1'b0;
    relative      = 1'b0;
    wr_en         = 1'b0;
    add_offset    = 1'b0;
    counteradress = '0;
    op_valid      = 1'b0;
    op_code       = '0;

    case (state_q)
      FETCH_OP: begin
        case (instr)
          OP_JMP:  begin kind_d = BR_JMP; state_d = FETCH_ARG; end
          OP_JR:   begin kind_d = BR_JR;  state_d = FETCH_ARG; end
          OP_JZ:   begin kind_d = BR_JZ;  state_d = FETCH_ARG; end
          OP_JC:   begin kind_d = BR_JC;  state_d = FETCH_ARG; end
          OP_HALT: begin
            wr_en         = 1'b1;
            counteradress = pc;
            state_d       = HALT;
          end
          default: begin
            op_valid = 1'b1;
            op_code  = instr;
          end
        endcase
      end
      FETCH_ARG: begin
        case (kind_q)
          BR_JMP:  taken = 1'b1;
          BR_JR:   begin taken = 1'b1;  relative = 1'b1; end
          BR_JZ:   taken = zero;
          BR_JC:   begin taken = carry; relative = 1'b1; end
          default: taken = 1'b0;
        endcase
        if (taken) begin
          wr_en      = 1'b1;
          add_offset = relative;
          // Offsets are two's complement, so widen them signed; absolute targets zero-extend.
          counteradress = relative ? PC_WIDTH'($signed(instr)) : PC_WIDTH'(instr);
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
        kind_d  = BR_NONE;
        state_d = FETCH_OP;
      end
      HALT: begin
        wr_en         = 1'b1;
        counteradress = pc;
      end
      default: state_d = FETCH_OP;
    endcase

    // Reset must silence the PC controls immediately, not just at the next edge.
    if (res) begin
      wr_en         = 1'b0;
      add_offset    = 1'b0;
      counteradress = '0;
      op_valid      = 1'b0;
      op_code       = '0;
    end
  end

  assign halted       = (state_q == HALT);
  assign branch_count = count_q;

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Bench for branch_fetch_ctrl: a behavioural PC + ROM environment and an
// instruction-level reference model of the branch semantics.
module tb_branch_fetch_ctrl;

  logic       clk, res, zero, carry;
  logic [7:0] pc_r, instr;
  logic       wr_en, add_offset, op_valid, halted;
  logic [7:0] counteradress, op_code, branch_count;

  logic [7:0] rom [256];
  assign instr = rom[pc_r];

  branch_fetch_ctrl #(.PC_WIDTH(8)) dut (
    .clk(clk), .res(res), .pc(pc_r), .instr(instr), .zero(zero), .carry(carry),
    .wr_en(wr_en), .add_offset(add_offset), .counteradress(counteradress),
    .op_valid(op_valid), .op_code(op_code), .halted(halted), .branch_count(branch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: program position, pending branch operand, halt, taken count.
  logic [7:0] m_pc, m_kind, m_count;
  logic       m_arg, m_halt;

  function automatic logic pick(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return !m_arg;
    endcase
  endfunction

  function automatic logic is_branch(input logic [7:0] b);
    return (b == 8'hF0) || (b == 8'hF4) || (b == 8'hF8) || (b == 8'hFC);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset(input logic [7:0] start);
    @(negedge clk);
    res = 1'b1;
    zero = 1'($urandom_range(0, 1));
    carry = 1'($urandom_range(0, 1));
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %0b expected 0", wr_en); end
    tests++; if (add_offset !== 1'b0) begin fails++; $display("FAIL reset_add_offset got %0b expected 0", add_offset); end
    tests++; if (counteradress !== 8'h00) begin fails++; $display("FAIL reset_counteradress got %02h expected 00", counteradress); end
    tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL reset_op_valid got %0b expected 0", op_valid); end
    tests++; if (op_code !== 8'h00) begin fails++; $display("FAIL reset_op_code got %02h expected 00", op_code); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %0b expected 0", halted); end
    tests++; if (branch_count !== 8'h00) begin fails++; $display("FAIL reset_branch_count got %0d expected 0", branch_count); end
    @(posedge clk);
    #1;
    res = 1'b0;
    pc_r = start;
    m_pc = start; m_kind = 8'h00; m_count = 8'h00; m_arg = 1'b0; m_halt = 1'b0;
  endtask

  // Runs n cycles; zmode/cmode: 0 low, 1 high, 2 random, 3 high only outside operand cycles.
  task automatic run(input int n, input int zmode, input int cmode, input string tag);
    logic [7:0] e_pc, e_code, e_ca, b, nxt, pc_next;
    logic       e_opv, e_wr, e_ao, e_halt, tk, rl, bump;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      zero  = pick(zmode);
      carry = pick(cmode);
      #1;
      e_pc = m_pc; e_opv = 1'b0; e_code = 8'h00; e_wr = 1'b0; e_ao = 1'b0;
      e_ca = 8'h00; e_halt = m_halt; bump = 1'b0; nxt = m_pc;
      if (m_halt) begin
        e_wr = 1'b1; e_ca = m_pc;
      end else if (m_arg) begin
        b  = rom[m_pc];
        tk = (m_kind == 8'hF0) || (m_kind == 8'hF4) || (m_kind == 8'hF8 && zero) || (m_kind == 8'hFC && carry);
        rl = (m_kind == 8'hF4) || (m_kind == 8'hFC);
        e_wr = tk; e_ao = tk && rl; e_ca = tk ? b : 8'h00;
        nxt  = !tk ? m_pc + 8'd1 : (rl ? m_pc + 8'd1 + b : b);
        bump = tk; m_arg = 1'b0;
      end else begin
        b = rom[m_pc];
        if (b == 8'hFF) begin
          e_wr = 1'b1; e_ca = m_pc; m_halt = 1'b1;
        end else if (is_branch(b)) begin
          m_kind = b; m_arg = 1'b1; nxt = m_pc + 8'd1;
        end else begin
          e_opv = 1'b1; e_code = b; nxt = m_pc + 8'd1;
        end
      end
      tests++; if (pc_r !== e_pc) begin fails++; $display("FAIL %s_pc cyc%0d got %02h expected %02h", tag, c, pc_r, e_pc); end
      tests++; if (op_valid !== e_opv) begin fails++; $display("FAIL %s_op_valid cyc%0d pc=%02h got %0b expected %0b", tag, c, pc_r, op_valid, e_opv); end
      if (e_opv) begin
        tests++; if (op_code !== e_code) begin fails++; $display("FAIL %s_op_code cyc%0d pc=%02h got %02h expected %02h", tag, c, pc_r, op_code, e_code); end
      end
      tests++; if (wr_en !== e_wr) begin fails++; $display("FAIL %s_wr_en cyc%0d pc=%02h got %0b expected %0b", tag, c, pc_r, wr_en, e_wr); end
      tests++; if (add_offset !== e_ao) begin fails++; $display("FAIL %s_add_offset cyc%0d pc=%02h got %0b expected %0b", tag, c, pc_r, add_offset, e_ao); end
      tests++; if (counteradress !== e_ca) begin fails++; $display("FAIL %s_counteradress cyc%0d pc=%02h got %02h expected %02h", tag, c, pc_r, counteradress, e_ca); end
      tests++; if (halted !== e_halt) begin fails++; $display("FAIL %s_halted cyc%0d pc=%02h got %0b expected %0b", tag, c, pc_r, halted, e_halt); end
      tests++; if (branch_count !== m_count) begin fails++; $display("FAIL %s_branch_count cyc%0d pc=%02h got %0d expected %0d", tag, c, pc_r, branch_count, m_count); end
      if (bump && m_count != 8'hFF) m_count = m_count + 8'd1;
      m_pc = nxt;
      pc_next = wr_en ? (add_offset ? pc_r + counteradress + 8'd1 : counteradress) : pc_r + 8'd1;
      @(posedge clk);
      #1;
      pc_r = pc_next;
    end
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset(8'h00);
    run(2, 2, 2, "reset_exit");
  endtask

  task automatic test_ordinary();
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hF1; rom[3] = 8'hF5; rom[4] = 8'hFE; rom[5] = 8'hF9;
    do_reset(8'h00);
    run(7, 2, 2, "ordinary");
  endtask

  task automatic test_jmp();
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'hF0; rom[2] = 8'h20;
    do_reset(8'h00);
    run(6, 2, 2, "jmp");
  endtask

  task automatic test_jr_jc();
    clear_rom();
    rom[8'h20] = 8'hF4; rom[8'h21] = 8'h08;
    rom[8'h30] = 8'hFC; rom[8'h31] = 8'hFD;
    do_reset(8'h20);
    run(16, 2, 1, "jr_jc");
    rom[8'hFF] = 8'hF4; rom[8'h00] = 8'h02;
    do_reset(8'hFF);
    run(4, 2, 2, "wrap");
  endtask

  task automatic test_jz();
    clear_rom();
    rom[8'h50] = 8'hF8; rom[8'h51] = 8'h70;
    do_reset(8'h50);
    run(3, 0, 2, "jz_not_taken");
    do_reset(8'h50);
    run(3, 1, 2, "jz_taken");
    do_reset(8'h50);
    run(3, 3, 2, "jz_opcode_flag_only");
  endtask

  task automatic test_halt();
    clear_rom();
    rom[8'h40] = 8'hFF;
    do_reset(8'h3E);
    run(15, 2, 2, "halt");
    do_reset(8'h40);
    run(2, 2, 2, "halt_after_reset");
  endtask

  task automatic test_reset_mid_branch();
    clear_rom();
    rom[1] = 8'hF0; rom[2] = 8'h20;
    do_reset(8'h00);
    run(2, 2, 2, "mid_pre");
    do_reset(8'h02);
    run(3, 2, 2, "mid_post");
  endtask

  task automatic test_saturation();
    clear_rom();
    rom[0] = 8'hF0; rom[1] = 8'h00;
    do_reset(8'h00);
    run(602, 2, 2, "saturate");
    tests++; if (branch_count !== 8'd255) begin fails++; $display("FAIL saturate_final got %0d expected 255", branch_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: b = 8'hF0;
            1: b = 8'hF4;
            2: b = 8'hF8;
            default: b = 8'hFC;
          endcase
        end
        if (b == 8'hFF) b = 8'h00;
        rom[i] = b;
      end
      do_reset(8'($urandom));
      run(300, 2, 2, "random");
    end
  endtask

  initial begin
    res = 1'b1; zero = 1'b0; carry = 1'b0; pc_r = 8'h00;
    m_pc = 8'h00; m_kind = 8'h00; m_count = 8'h00; m_arg = 1'b0; m_halt = 1'b0;
    clear_rom();
    test_reset();
    test_ordinary();
    test_jmp();
    test_jr_jc();
    test_jz();
    test_halt();
    test_reset_mid_branch();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_fetch_ctrl.md
# branch_fetch_ctrl

Instruction-stream front end for the 8-bit core. Each cycle it watches the byte the program ROM returns at the current program-counter value. It forwards ordinary opcodes to the execute path. For two-byte branch instructions and HALT, it generates the `wr_en` / `add_offset` / `counteradress` controls that the program counter consumes. It sits between the program ROM and the program counter: the controlling end of the PC's load/offset interface.

## Interface
- `PC_WIDTH`, default 8: width of the program address and of all address/offset fields.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `res`  in  1  asynchronous, active-high reset.
- `pc`  in  PC_WIDTH  current program counter value.
- `instr`  in  8  ROM byte at address `pc`, valid combinationally in the same cycle.
- `zero`  in  1  ALU zero flag, sampled in the operand cycle.
- `carry`  in  1  ALU carry flag, sampled in the operand cycle.
- `wr_en`  out  1  PC load strobe; the PC acts on it at the next edge.
- `add_offset`  out  1  with `wr_en`: 1 = relative load (pc <= pc + counteradress + 1), 0 = absolute load (pc <= counteradress).
- `counteradress`  out  PC_WIDTH  target address or offset for the PC.
- `op_valid`  out  1  `op_code` holds an ordinary instruction to execute this cycle.
- `op_code`  out  8  forwarded opcode.
- `halted`  out  1  core stopped; set only by HALT, cleared only by reset.
- `branch_count`  out  8  count of taken branches, saturating at 255.

## Operation
- Registered states:
  - FETCH_OP: opcode cycle.
  - FETCH_ARG: operand cycle.
  - HALT.
- Branch-decision outputs are Mealy: combinational from state, `instr` and flags.
- Decode of `instr` in FETCH_OP:
  - 0xF0 JMP: absolute, unconditional.
  - 0xF4 JR: relative, unconditional.
  - 0xF8 JZ: absolute, taken if `zero`.
  - 0xFC JC: relative, taken if `carry`.
  - 0xFF HALT.
  - Any other byte, including other 0xFx values, is an ordinary instruction.
- Ordinary instruction in FETCH_OP:
  - `op_valid`=1, `op_code`=`instr`, `wr_en`=0.
  - Stay in FETCH_OP; the PC increments by itself.
- Branch opcode in FETCH_OP:
  - `op_valid`=0, `wr_en`=0.
  - Latch the branch kind; go to FETCH_ARG.
- FETCH_ARG (pc = opcode address + 1, `instr` = operand byte):
  - `op_valid`=0; the operand byte is never executed.
  - Taken: `wr_en`=1, `counteradress`=`instr`, `add_offset`=1 for JR/JC and 0 for JMP/JZ. Increment `branch_count` unless it is already 255.
  - Not taken: `wr_en`=0; the PC steps to operand address + 1.
  - Always return to FETCH_OP.
- HALT seen in FETCH_OP:
  - Same cycle: `wr_en`=1, `add_offset`=0, `counteradress`=`pc`, `op_valid`=0. The PC reloads itself.
  - Go to HALT.
- HALT state:
  - Hold `wr_en`=1, `add_offset`=0, `counteradress`=`pc`, `halted`=1 every cycle.
  - Ignore `instr` and the flags.
- Relative arithmetic is performed by the PC modulo 2^PC_WIDTH. The effective target is operand address + 1 + offset, wrapped. Backward branches therefore use two's-complement offsets (0xFD = -3).
- Outside a load, `counteradress` = 0 and `add_offset` = 0. Both are don't-care whenever `wr_en`=0, but are driven to 0.

## Timing
- Reset (asynchronous, any state, including mid-FETCH_ARG):
  - State goes to FETCH_OP.
  - `halted`=0, `branch_count`=0, latched branch kind cleared.
  - While `res` is high: `wr_en`=0, `add_offset`=0, `counteradress`=0, `op_valid`=0, `op_code`=0.
- Latency:
  - Ordinary opcode: 0 cycles (`op_valid` in the cycle its byte is at `pc`).
  - Taken branch: 2 cycles from opcode address to target address.
  - Not-taken branch: 2 cycles to the sequential address.
- Flags are sampled only in the FETCH_ARG cycle; flag changes during FETCH_OP have no effect.
- A branch opcode at address 2^PC_WIDTH-1 takes its operand from address 0 (PC wrap). No special handling.
- Back-to-back branches are allowed: the target may itself hold a branch opcode.
- `branch_count` updates on the edge ending a taken FETCH_ARG cycle.

## Test plan
- Ordinary opcode: reset, ROM[0]=0x12, ROM[1]=0x34 -> `op_valid`=1 with `op_code`=0x12 at pc 0, then 0x34 at pc 1; `wr_en` stays 0.
- JMP: ROM[1]=0xF0, ROM[2]=0x20 -> at pc 2, `wr_en`=1, `add_offset`=0, `counteradress`=0x20; next pc=0x20; `op_valid`=0 at pc 1 and 2; `branch_count`=1.
- JR and JC backward:
  - ROM[0x20]=0xF4, ROM[0x21]=0x08 -> next pc=0x2A.
  - ROM[0x30]=0xFC, ROM[0x31]=0xFD with `carry`=1 -> next pc=0x2F.
  - `branch_count` increments on each.
- JZ not taken, then taken: ROM[0x50]=0xF8, ROM[0x51]=0x70.
  - `zero`=0 in the operand cycle -> `wr_en`=0, next pc=0x52, count unchanged.
  - Repeat with `zero`=1 -> next pc=0x70.
  - `zero`=1 only during the opcode cycle -> not taken.
- HALT: ROM[0x40]=0xFF -> `wr_en`=1, `counteradress`=0x40 every cycle; pc stays 0x40 for 10+ cycles; `halted`=1; then assert `res` -> `halted`=0, `wr_en`=0, state FETCH_OP.
- Reset mid-branch and saturation:
  - Assert `res` during the FETCH_ARG cycle of a JMP -> `wr_en`=0 immediately; after release the next byte decodes as an opcode.
  - Loop a taken JMP 300 times -> `branch_count`=255.
